mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
MEM/WB pipeline boundary for the 5-stage pipelined CPU. Handles the data-memory handshake for the MEM-stage access, including multi-cycle memory wait, stall generation and timeout. Aligns and extends load data per dm_ctrl. Registers the result and writeback controls into the WB stage.

Parameters:
TIMEOUT, 16, max WAIT cycles before abandoning an access (range 2..255)
CNT_W, 8, width of the wait counter

Ports:
clk  in  1  pipeline clock; all state on rising edge
rstn  in  1  asynchronous active-low reset
MEM_valid  in  1  MEM stage holds a real instruction
MEM_aluout  in  32  access address / ALU result
MEM_dm_ctrl  in  3  access size/sign code
MEM_mem_r  in  1  instruction is a load
MEM_mem_w  in  1  instruction is a store
MEM_Data_in  in  32  raw word returned by data memory
mem_ready  in  1  data memory completes the current access this cycle
MEM_rd  in  5  destination register
MEM_RegWrite  in  1  register write enable
MEM_WDSel  in  2  writeback mux select
MEM_PC  in  32  instruction PC
flush  in  1  kill the instruction leaving MEM
mem_stall  out  1  freeze PC/IF/ID/EX/MEM (combinational)
bus_err  out  1  one-cycle pulse on timeout
WB_valid  out  1  WB holds a real instruction
WB_aluout  out  32  registered ALU result
WB_MemData  out  32  aligned, extended load data
WB_rd  out  5  registered destination
WB_RegWrite  out  1  registered write enable (0 for bubbles)
WB_WDSel  out  2  registered mux select
WB_PC  out  32  registered PC

Behaviour:
- Reset (rstn=0, async): all outputs 0; state=IDLE; counter=0; kill flag=0.
- access = MEM_valid & (MEM_mem_r | MEM_mem_w).
- States:
  - IDLE:
    - access & ~mem_ready -> WAIT, counter=1.
    - Otherwise stay IDLE.
  - WAIT:
    - mem_ready -> IDLE.
    - counter==TIMEOUT-1 & ~mem_ready -> IDLE with bus_err=1 for one cycle.
    - Otherwise counter+1.
- mem_stall = access & ~mem_ready, in IDLE or WAIT.
  - Forced 0 on the timeout cycle.
  - Upstream holds all MEM_* inputs stable while mem_stall=1.
- WB register update on every edge where mem_stall=0:
  - If (flush | kill) or ~MEM_valid or timeout: bubble.
    - WB_valid=0, WB_RegWrite=0.
    - Other WB fields still capture the inputs; they are don't-care.
  - Otherwise capture all MEM_* fields, WB_valid=1.
  - Load result latency: 1 cycle after the mem_ready cycle.
- While mem_stall=1:
  - WB_valid=0 and WB_RegWrite=0 (bubble into WB).
  - flush sets the sticky kill flag; kill clears when the access completes.
  - A killed store still completes on the bus (no abort). Only writeback is suppressed.
- Load extraction from MEM_Data_in with off = MEM_aluout[1:0]:
  - 000 word: data as is; off ignored.
  - 001 half signed: half = aluout[1] ? [31:16] : [15:0]; sign-extend. aluout[0] ignored.
  - 010 half unsigned: same half; zero-extend.
  - 011 byte signed: byte lane off; sign-extend.
  - 100 byte unsigned: byte lane off; zero-extend.
  - 101..111: treated as word.
- Stores: WB_MemData is don't-care; bench ignores it when MEM_mem_r=0.
- Simultaneous mem_ready and counter limit: ready wins, no bus_err.
- Reset mid-WAIT: returns to IDLE immediately; mem_stall deasserts once rstn=0.

Decomposition:
- Shared package cpu_pkg:
  - dm_ctrl constants: DM_WORD=3'b000, DM_HALF=3'b001, DM_HALF_U=3'b010, DM_BYTE=3'b011, DM_BYTE_U=3'b100.
  - FSM state encoding: ST_IDLE, ST_WAIT.
- One combinational sub-module: load_align (inputs dm_ctrl, addr[1:0], raw word; output extended 32-bit word).

Test Plan:
- lw, 0-wait: MEM_aluout=0x100, dm_ctrl=000, Data_in=0xDEADBEEF, mem_ready=1 same cycle -> mem_stall never 1; next cycle WB_MemData=0xDEADBEEF, WB_valid=1, WB_RegWrite=1.
- lb, 2-cycle wait: addr=0x103, dm_ctrl=011, Data_in=0x80FF1234, mem_ready on 3rd cycle -> mem_stall=1 for 2 cycles; then WB_MemData=0xFFFFFF80. Same with lbu -> 0x00000080.
- lh/lhu: addr=0x102, Data_in=0x9ABC5678 -> lh gives 0xFFFF9ABC, lhu gives 0x00009ABC. With addr=0x100, lh -> 0x00005678.
- Timeout (TIMEOUT=4): load, mem_ready held 0 -> mem_stall=1 for 3 cycles; bus_err pulses on the 4th; WB_valid=0; pipeline resumes the next cycle.
- Flush during WAIT: store, flush=1 in the 1st stall cycle, ready on the 3rd -> WB_valid=0 and WB_RegWrite=0 after completion; a following lw at 0x0 with 0-wait writes back normally.
- Reset mid-WAIT: rstn=0 during stall -> all outputs 0 asynchronously. After release, a fresh 0-wait lw completes in 1 cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared dm_ctrl codes and MEM/WB state encoding
package cpu_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the addressed half/byte of a load word and extends it
module load_align
  import cpu_pkg::*;
(
  input  logic [2:0]  dm_ctrl,
  input  logic [1:0]  addr,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  logic [15:0] half;
  logic [7:0]  lane;

  // pick the lane selected by the low address bits, then extend per access size
  always_comb begin
    half = addr[1] ? raw[31:16] : raw[15:0];
    case (addr)
      2'd0:    lane = raw[7:0];
      2'd1:    lane = raw[15:8];
      2'd2:    lane = raw[23:16];
      default: lane = raw[31:24];
    endcase
    case (dm_ctrl)
      DM_HALF:   data = {{16{half[15]}}, half};
      DM_HALF_U: data = {16'h0000, half};
      DM_BYTE:   data = {{24{lane[7]}}, lane};
      DM_BYTE_U: data = {24'h000000, lane};
      default:   data = raw;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB boundary: data-memory wait/stall/timeout and WB register
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        MEM_valid,
  input  logic [31:0] MEM_aluout,
  input  logic [2:0]  MEM_dm_ctrl,
  input  logic        MEM_mem_r,
  input  logic        MEM_mem_w,
  input  logic [31:0] MEM_Data_in,
  input  logic        mem_ready,
  input  logic [4:0]  MEM_rd,
  input  logic        MEM_RegWrite,
  input  logic [1:0]  MEM_WDSel,
  input  logic [31:0] MEM_PC,
  input  logic        flush,
  output logic        mem_stall,
  output logic        bus_err,
  output logic        WB_valid,
  output logic [31:0] WB_aluout,
  output logic [31:0] WB_MemData,
  output logic [4:0]  WB_rd,
  output logic        WB_RegWrite,
  output logic [1:0]  WB_WDSel,
  output logic [31:0] WB_PC
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             kill;
  logic             access;
  logic             cnt_at_limit;
  logic             timeout;
  logic             wb_bubble;
  logic [31:0]      load_data;

  load_align u_load_align (
    .dm_ctrl (MEM_dm_ctrl),
    .addr    (MEM_aluout[1:0]),
    .raw     (MEM_Data_in),
    .data    (load_data)
  );

  // decode the access request and the wait-limit condition
  always_comb begin
    access       = MEM_valid & (MEM_mem_r | MEM_mem_w);
    cnt_at_limit = (cnt == CNT_W'(TIMEOUT - 1));
  end

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // next state: enter WAIT on an unfinished access, leave on ready or limit
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (access & ~mem_ready) state_nxt = ST_WAIT;
      ST_WAIT: if (~access | mem_ready | cnt_at_limit) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // outputs: ready beats the limit; the timeout cycle releases the pipeline
  always_comb begin
    timeout   = (state == ST_WAIT) & access & ~mem_ready & cnt_at_limit;
    bus_err   = timeout;
    mem_stall = rstn & access & ~mem_ready & ~timeout;
    wb_bubble = flush | kill | ~MEM_valid | timeout;
  end

  // wait counter: 1 on the first WAIT cycle, counts while waiting
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                     cnt <= '0;
    else if (state_nxt != ST_WAIT) cnt <= '0;
    else if (state == ST_IDLE)     cnt <= CNT_W'(1);
    else                           cnt <= cnt + CNT_W'(1);
  end

  // sticky kill: a flush seen while stalled suppresses writeback at completion
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          kill <= 1'b0;
    else if (mem_stall) kill <= kill | flush;
    else                kill <= 1'b0;
  end

  // WB register: capture when not stalled, inject bubbles otherwise
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      WB_valid    <= 1'b0;
      WB_RegWrite <= 1'b0;
      WB_aluout   <= '0;
      WB_MemData  <= '0;
      WB_rd       <= '0;
      WB_WDSel    <= '0;
      WB_PC       <= '0;
    end else if (!mem_stall) begin
      WB_valid    <= ~wb_bubble;
      WB_RegWrite <= MEM_RegWrite & ~wb_bubble;
      WB_aluout   <= MEM_aluout;
      WB_MemData  <= load_data;
      WB_rd       <= MEM_rd;
      WB_WDSel    <= MEM_WDSel;
      WB_PC       <= MEM_PC;
    end else begin
      WB_valid    <= 1'b0;
      WB_RegWrite <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage with a behavioural model
module tb_mem_wb_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        MEM_valid;
  logic [31:0] MEM_aluout;
  logic [2:0]  MEM_dm_ctrl;
  logic        MEM_mem_r;
  logic        MEM_mem_w;
  logic [31:0] MEM_Data_in;
  logic        mem_ready;
  logic [4:0]  MEM_rd;
  logic        MEM_RegWrite;
  logic [1:0]  MEM_WDSel;
  logic [31:0] MEM_PC;
  logic        flush;
  logic        mem_stall;
  logic        bus_err;
  logic        WB_valid;
  logic [31:0] WB_aluout;
  logic [31:0] WB_MemData;
  logic [4:0]  WB_rd;
  logic        WB_RegWrite;
  logic [1:0]  WB_WDSel;
  logic [31:0] WB_PC;

  mem_wb_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .MEM_valid    (MEM_valid),
    .MEM_aluout   (MEM_aluout),
    .MEM_dm_ctrl  (MEM_dm_ctrl),
    .MEM_mem_r    (MEM_mem_r),
    .MEM_mem_w    (MEM_mem_w),
    .MEM_Data_in  (MEM_Data_in),
    .mem_ready    (mem_ready),
    .MEM_rd       (MEM_rd),
    .MEM_RegWrite (MEM_RegWrite),
    .MEM_WDSel    (MEM_WDSel),
    .MEM_PC       (MEM_PC),
    .flush        (flush),
    .mem_stall    (mem_stall),
    .bus_err      (bus_err),
    .WB_valid     (WB_valid),
    .WB_aluout    (WB_aluout),
    .WB_MemData   (WB_MemData),
    .WB_rd        (WB_rd),
    .WB_RegWrite  (WB_RegWrite),
    .WB_WDSel     (WB_WDSel),
    .WB_PC        (WB_PC)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] alu;
    logic [2:0]  dm;
    logic        r;
    logic        w;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  wdsel;
    logic [31:0] pc;
    int          d;
    logic [7:0]  fmask;
  } instr_t;

  typedef struct {
    logic        stall;
    logic        berr;
    logic        v;
    logic        rwx;
    logic        chk;
    logic        chkd;
    logic [31:0] alu;
    logic [31:0] data;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [1:0]  wdsel;
    int          epoch;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   epoch  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] dm, input logic [31:0] addr,
                                           input logic [31:0] raw);
    int          width;
    int          sh;
    logic        sgn;
    logic [31:0] mask;
    logic [31:0] v;
    case (dm)
      3'd1: begin width = 16; sh = addr[1] ? 16 : 0;  sgn = 1'b1; end
      3'd2: begin width = 16; sh = addr[1] ? 16 : 0;  sgn = 1'b0; end
      3'd3: begin width = 8;  sh = 8 * int'(addr[1:0]); sgn = 1'b1; end
      3'd4: begin width = 8;  sh = 8 * int'(addr[1:0]); sgn = 1'b0; end
      default: return raw;
    endcase
    mask = (32'h1 << width) - 32'h1;
    v = (raw >> sh) & mask;
    if (sgn && ((v >> (width - 1)) & 32'h1) != 0) v = v | ~mask;
    return v;
  endfunction

  function automatic instr_t mk(input logic valid, input logic [31:0] alu, input logic [2:0] dm,
                                input logic r, input logic w, input logic [31:0] data,
                                input int d, input logic [7:0] fmask);
    instr_t i;
    i.valid = valid; i.alu = alu; i.dm = dm; i.r = r; i.w = w; i.data = data;
    i.rd = 5'($urandom); i.rw = r | ($urandom_range(0, 1) == 1);
    i.wdsel = 2'($urandom); i.pc = $urandom & 32'hFFFF_FFFC;
    i.d = d; i.fmask = fmask;
    return i;
  endfunction

  function automatic instr_t rnd_instr();
    instr_t i;
    int     kind;
    logic [7:0] fm;
    kind = $urandom_range(0, 2);
    fm = '0;
    for (int b = 0; b < 8; b++) fm[b] = ($urandom_range(0, 7) == 0);
    i = mk($urandom_range(0, 7) != 0, $urandom, 3'($urandom), kind == 0, kind == 1,
           $urandom, $urandom_range(0, TO + 1), fm);
    return i;
  endfunction

  task automatic set_idle();
    MEM_valid = 1'b0; MEM_mem_r = 1'b0; MEM_mem_w = 1'b0; MEM_RegWrite = 1'b0;
    MEM_aluout = '0; MEM_dm_ctrl = '0; MEM_Data_in = '0; MEM_rd = '0;
    MEM_WDSel = '0; MEM_PC = '0; mem_ready = 1'b0; flush = 1'b0;
  endtask

  // one instruction occupies MEM until its access finishes (or never stalls)
  task automatic run_instr(input instr_t in);
    logic acc;
    logic tmo;
    logic killed;
    int   last;
    exp_t e;
    acc    = in.valid & (in.r | in.w);
    last   = acc ? ((in.d < TO - 1) ? in.d : TO - 1) : 0;
    tmo    = acc && (in.d >= TO);
    killed = 1'b0;
    for (int k = 0; k <= last; k++) killed = killed | in.fmask[k];
    for (int k = 0; k <= last; k++) begin
      @(posedge clk); #1;
      MEM_valid = in.valid; MEM_aluout = in.alu; MEM_dm_ctrl = in.dm;
      MEM_mem_r = in.r; MEM_mem_w = in.w; MEM_Data_in = in.data;
      MEM_rd = in.rd; MEM_RegWrite = in.rw; MEM_WDSel = in.wdsel; MEM_PC = in.pc;
      mem_ready = acc ? (k == in.d) : ($urandom_range(0, 1) == 1);
      flush = in.fmask[k];
      e.stall = acc && (k < last);
      e.berr  = tmo && (k == last);
      if (k < last) e.v = 1'b0;
      else          e.v = in.valid & ~killed & ~tmo;
      e.rwx   = e.v & in.rw;
      e.chk   = e.v;
      e.chkd  = e.v & in.r;
      e.alu   = in.alu;
      e.data  = ref_load(in.dm, in.alu, in.data);
      e.pc    = in.pc;
      e.rd    = in.rd;
      e.wdsel = in.wdsel;
      e.epoch = epoch;
      q.push_back(e);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_stall"}, 32'(mem_stall), 32'h0);
    check({tag, "_bus_err"}, 32'(bus_err), 32'h0);
    check({tag, "_wb_valid"}, 32'(WB_valid), 32'h0);
    check({tag, "_wb_regwrite"}, 32'(WB_RegWrite), 32'h0);
    check({tag, "_wb_aluout"}, WB_aluout, 32'h0);
    check({tag, "_wb_memdata"}, WB_MemData, 32'h0);
    check({tag, "_wb_rd"}, 32'(WB_rd), 32'h0);
    check({tag, "_wb_wdsel"}, 32'(WB_WDSel), 32'h0);
    check({tag, "_wb_pc"}, WB_PC, 32'h0);
  endtask

  // monitor: pops one expectation per cycle; WB is checked one cycle later
  initial begin
    exp_t r;
    exp_t prev;
    logic have_prev;
    have_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        r = q.pop_front();
        check("mem_stall", 32'(mem_stall), 32'(r.stall));
        check("bus_err", 32'(bus_err), 32'(r.berr));
        if (have_prev && prev.epoch == r.epoch) begin
          check("wb_valid", 32'(WB_valid), 32'(prev.v));
          check("wb_regwrite", 32'(WB_RegWrite), 32'(prev.rwx));
          if (prev.chk) begin
            check("wb_aluout", WB_aluout, prev.alu);
            check("wb_rd", 32'(WB_rd), 32'(prev.rd));
            check("wb_wdsel", 32'(WB_WDSel), 32'(prev.wdsel));
            check("wb_pc", WB_PC, prev.pc);
          end
          if (prev.chkd) check("wb_memdata", WB_MemData, prev.data);
        end
        prev = r;
        have_prev = 1'b1;
      end
    end
  end

  initial begin
    rstn = 1'b0;
    set_idle();
    #3;
    check_all_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;

    run_instr(mk(1, 32'h100, 3'b000, 1, 0, 32'hDEADBEEF, 0, 8'h00));
    run_instr(mk(1, 32'h103, 3'b011, 1, 0, 32'h80FF1234, 2, 8'h00));
    run_instr(mk(1, 32'h103, 3'b100, 1, 0, 32'h80FF1234, 2, 8'h00));
    run_instr(mk(1, 32'h102, 3'b001, 1, 0, 32'h9ABC5678, 1, 8'h00));
    run_instr(mk(1, 32'h102, 3'b010, 1, 0, 32'h9ABC5678, 0, 8'h00));
    run_instr(mk(1, 32'h100, 3'b001, 1, 0, 32'h9ABC5678, 0, 8'h00));
    run_instr(mk(1, 32'h200, 3'b000, 1, 0, 32'h12345678, 255, 8'h00));
    run_instr(mk(1, 32'h204, 3'b000, 1, 0, 32'h0BADF00D, TO - 1, 8'h00));
    run_instr(mk(1, 32'h300, 3'b000, 0, 1, 32'h0, 2, 8'h01));
    run_instr(mk(1, 32'h000, 3'b000, 1, 0, 32'hCAFEF00D, 0, 8'h00));
    run_instr(mk(0, 32'h0, 3'b000, 0, 0, 32'h0, 0, 8'h00));

    // asynchronous reset while an access is waiting
    @(posedge clk); #1;
    set_idle();
    MEM_valid = 1'b1; MEM_mem_r = 1'b1; MEM_RegWrite = 1'b1; MEM_aluout = 32'h40;
    @(negedge clk);
    check("rst_pre_stall", 32'(mem_stall), 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    check_all_zero("midwait_reset");
    @(posedge clk); #1;
    set_idle();
    rstn = 1'b1;
    epoch++;
    run_instr(mk(1, 32'h0, 3'b000, 1, 0, 32'h13579BDF, 0, 8'h00));

    for (int n = 0; n < 300; n++) run_instr(rnd_instr());
    for (int n = 0; n < 3; n++) run_instr(mk(0, 32'h0, 3'b000, 0, 0, 32'h0, 0, 8'h00));
    @(posedge clk); #1;
    set_idle();
    for (int n = 0; n < 10 && q.size() > 0; n++) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
